// File: rtl/lsu_bridge_pkg.sv
// Shared types for the LSU-to-Avalon bridge.
// txn_kind_e     : kind of an accepted transaction held in the in-order tracker.
// AVM_RESP_OKAY  : Avalon response code for a successful transfer.
package lsu_bridge_pkg;

  typedef enum logic {
    TXN_READ  = 1'b0,
    TXN_WRITE = 1'b1
  } txn_kind_e;

  localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_txn_fifo.sv
// In-order tracker of accepted Avalon transactions (one kind bit per entry).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the tracker)
//   push       : enqueue push_kind at the tail
//   push_kind  : kind of the transaction being enqueued
//   pop        : dequeue the head entry
//   head       : kind of the oldest outstanding transaction
//   count      : number of outstanding entries
//   full/empty : occupancy flags
//   has_write  : at least one WRITE entry is outstanding
module lsu_txn_fifo
  import lsu_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  txn_kind_e                  push_kind,
  input  logic                       pop,
  output txn_kind_e                  head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       has_write
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  txn_kind_e        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wr_count;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + PTR_W'(1);
  endfunction

  logic push_wr;
  logic pop_wr;

  assign push_wr   = push && (push_kind == TXN_WRITE);
  assign pop_wr    = pop && (head == TXN_WRITE);
  assign head      = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign has_write = (wr_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      case ({push_wr, pop_wr})
        2'b10:   wr_count <= wr_count + CNT_W'(1);
        2'b01:   wr_count <= wr_count - CNT_W'(1);
        default: wr_count <= wr_count;
      endcase
    end
  end

endmodule

// File: rtl/lsu_avalon_bridge.sv
// Core LSU port to pipelined Avalon-MM master bridge.
// The command path is combinational; accepted transactions are tracked in
// order, read data/response and a synthesised write-completion strobe are
// returned through one registered stage.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   lsu_read/lsu_write/lsu_addr/
//   lsu_be/lsu_wdata                  : core request (held while lsu_busy)
//   lsu_busy                          : request not accepted this cycle
//   lsu_rvalid/lsu_rdata/lsu_resp     : registered read return
//   lsu_wrespvalid                    : registered write completion
//   avm_*                             : Avalon-MM master (no writeresponsevalid)
//   proto_err                         : sticky, readdatavalid with no read at head
module lsu_avalon_bridge
  import lsu_bridge_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_read,
  input  logic                  lsu_write,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [3:0]            lsu_be,
  input  logic [31:0]           lsu_wdata,
  output logic                  lsu_busy,
  output logic                  lsu_rvalid,
  output logic [31:0]           lsu_rdata,
  output logic [1:0]            lsu_resp,
  output logic                  lsu_wrespvalid,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [3:0]            avm_byteenable,
  output logic [31:0]           avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid,
  input  logic [31:0]           avm_readdata,
  input  logic [1:0]            avm_response,
  output logic                  proto_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  txn_kind_e        fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_has_write;
  txn_kind_e        push_kind;
  logic             accept;
  logic             pop_read;
  logic             pop_write;
  logic             stray_rdv;

  logic             rd_vld_p1;
  logic             wr_vld_p1;
  logic [31:0]      rdata_p1;
  logic [1:0]       resp_p1;
  logic             proto_err_q;

  lsu_txn_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_txn_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_kind (push_kind),
    .pop       (pop_read | pop_write),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .has_write (fifo_has_write)
  );

  // full is defined on the occupancy count; keep the tracker's flag honest.
  assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CNT_W'(MAX_OUTSTANDING)));

  assign avm_address    = lsu_addr;
  assign avm_byteenable = lsu_be;
  assign avm_writedata  = lsu_wdata;

  // Reads wait behind any outstanding write so that readdatavalid can never
  // arrive while a write sits at the head of the tracker.
  assign avm_read  = lsu_read & ~fifo_full & ~fifo_has_write;
  assign avm_write = lsu_write & ~fifo_full;
  assign accept    = (avm_read | avm_write) & ~avm_waitrequest;
  assign lsu_busy  = (lsu_read | lsu_write) & ~accept;
  assign push_kind = avm_write ? TXN_WRITE : TXN_READ;

  // The slave gives no write response, so a write at the head retires at once.
  assign pop_write = ~fifo_empty & (fifo_head == TXN_WRITE);
  assign pop_read  = ~fifo_empty & (fifo_head == TXN_READ) & avm_readdatavalid;
  assign stray_rdv = avm_readdatavalid & (fifo_empty | (fifo_head == TXN_WRITE));

  // ---- stage p1: registered response to the core ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_p1   <= 1'b0;
      wr_vld_p1   <= 1'b0;
      rdata_p1    <= '0;
      resp_p1     <= AVM_RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      rd_vld_p1 <= pop_read;
      wr_vld_p1 <= pop_write;
      if (pop_read) begin
        rdata_p1 <= avm_readdata;
        resp_p1  <= avm_response;
      end else if (pop_write) begin
        resp_p1 <= AVM_RESP_OKAY;
      end
      if (stray_rdv) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign lsu_rvalid     = rd_vld_p1;
  assign lsu_wrespvalid = wr_vld_p1;
  assign lsu_rdata      = rdata_p1;
  assign lsu_resp       = resp_p1;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_lsu_avalon_bridge.sv
module tb_lsu_avalon_bridge;

  localparam int MAXO = 4;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lsu_read = 1'b0;
  logic          lsu_write = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [3:0]    lsu_be = '0;
  logic [31:0]   lsu_wdata = '0;
  logic          lsu_busy;
  logic          lsu_rvalid;
  logic [31:0]   lsu_rdata;
  logic [1:0]    lsu_resp;
  logic          lsu_wrespvalid;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [3:0]    avm_byteenable;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic          avm_readdatavalid = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic [1:0]    avm_response = '0;
  logic          proto_err;

  lsu_avalon_bridge #(
    .MAX_OUTSTANDING (MAXO),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .lsu_read          (lsu_read),
    .lsu_write         (lsu_write),
    .lsu_addr          (lsu_addr),
    .lsu_be            (lsu_be),
    .lsu_wdata         (lsu_wdata),
    .lsu_busy          (lsu_busy),
    .lsu_rvalid        (lsu_rvalid),
    .lsu_rdata         (lsu_rdata),
    .lsu_resp          (lsu_resp),
    .lsu_wrespvalid    (lsu_wrespvalid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata),
    .avm_response      (avm_response),
    .proto_err         (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of outstanding kinds (1 = write) and the values
  // the core should see on its registered outputs after the next edge.
  bit          q[$];
  bit          exp_rvalid;
  bit          exp_wresp;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;
  bit          exp_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_rvalid = 0;
    exp_wresp  = 0;
    exp_rdata  = '0;
    exp_resp   = 2'b00;
    exp_perr   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lsu_read = 1'b0;
    lsu_write = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  // One clock cycle: drive inputs just after the edge, check everything on
  // the falling edge, advance the model, return just after the next edge.
  task automatic step(input bit rd, input bit wr, input bit wt, input bit rdv,
                      input logic [31:0] rdat, input logic [1:0] rsp, output bit acc);
    bit full, hw, er, ew, eb, head_wr, nonempty;
    lsu_read          = rd;
    lsu_write         = wr;
    lsu_addr          = $urandom;
    lsu_be            = 4'($urandom);
    lsu_wdata         = $urandom;
    avm_waitrequest   = wt;
    avm_readdatavalid = rdv;
    avm_readdata      = rdat;
    avm_response      = rsp;
    @(negedge clk);
    full = (q.size() == MAXO);
    hw = 0;
    foreach (q[i]) if (q[i]) hw = 1;
    er  = rd & !full & !hw;
    ew  = wr & !full;
    acc = (er | ew) & !wt;
    eb  = (rd | wr) & !acc;
    chk("avm_read", 32'(avm_read), 32'(er));
    chk("avm_write", 32'(avm_write), 32'(ew));
    chk("lsu_busy", 32'(lsu_busy), 32'(eb));
    chk("avm_address", avm_address, lsu_addr);
    chk("avm_byteenable", 32'(avm_byteenable), 32'(lsu_be));
    chk("avm_writedata", avm_writedata, lsu_wdata);
    chk("lsu_rvalid", 32'(lsu_rvalid), 32'(exp_rvalid));
    chk("lsu_wrespvalid", 32'(lsu_wrespvalid), 32'(exp_wresp));
    chk("lsu_rdata", lsu_rdata, exp_rdata);
    chk("lsu_resp", 32'(lsu_resp), 32'(exp_resp));
    chk("proto_err", 32'(proto_err), 32'(exp_perr));
    nonempty   = (q.size() != 0);
    head_wr    = nonempty && q[0];
    exp_rvalid = 0;
    exp_wresp  = 0;
    if (rdv && (!nonempty || head_wr)) exp_perr = 1;
    if (head_wr) begin
      void'(q.pop_front());
      exp_wresp = 1;
      exp_resp  = 2'b00;
    end else if (nonempty && rdv) begin
      void'(q.pop_front());
      exp_rvalid = 1;
      exp_rdata  = rdat;
      exp_resp   = rsp;
    end
    if (acc) q.push_back(ew);
    @(posedge clk);
    #1;
  endtask

  bit a;
  bit pend_rd, pend_wr;
  bit r_wt, r_rdv;

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_rvalid", 32'(lsu_rvalid), 0);
    chk("reset_wresp", 32'(lsu_wrespvalid), 0);
    chk("reset_rdata", lsu_rdata, 0);
    chk("reset_resp", 32'(lsu_resp), 0);
    chk("reset_perr", 32'(proto_err), 0);

    // Single read held off by waitrequest for two cycles.
    step(1, 0, 1, 0, 0, 0, a);
    step(1, 0, 1, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 32'hDEADBEEF, 2'b00, a);
    chk("t1_rvalid", 32'(lsu_rvalid), 1);
    chk("t1_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("t1_resp", 32'(lsu_resp), 0);
    step(0, 0, 0, 0, 0, 0, a);
    chk("t1_rvalid_one_cycle", 32'(lsu_rvalid), 0);

    // Fill to MAX_OUTSTANDING, fifth read stalls until data returns.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, a);
    lsu_read = 1'b1;
    #1;
    chk("t2_full_busy", 32'(lsu_busy), 1);
    chk("t2_full_avm_read", 32'(avm_read), 0);
    step(1, 0, 0, 1, 32'h1111_0001, 0, a);
    step(1, 0, 0, 0, 0, 0, a);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h2222_0000 + i, 0, a);
    step(0, 0, 0, 0, 0, 0, a);

    // Read, write, then a read that must wait behind the write.
    step(1, 0, 0, 0, 0, 0, a);
    step(0, 1, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, a);
    step(1, 0, 0, 1, 32'hCAFE_0001, 0, a);
    chk("t3_r1_rvalid", 32'(lsu_rvalid), 1);
    step(1, 0, 0, 0, 0, 0, a);
    chk("t3_wresp", 32'(lsu_wrespvalid), 1);
    lsu_read = 1'b1;
    #1;
    chk("t3_r2_issued", 32'(avm_read), 1);
    step(1, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 32'hCAFE_0002, 0, a);
    chk("t3_r2_rdata", lsu_rdata, 32'hCAFE_0002);

    // Three writes back to back: strobe for three cycles from T+2.
    step(0, 1, 0, 0, 0, 0, a);
    chk("t4_wresp_t1", 32'(lsu_wrespvalid), 0);
    step(0, 1, 0, 0, 0, 0, a);
    chk("t4_wresp_t2", 32'(lsu_wrespvalid), 1);
    step(0, 1, 0, 0, 0, 0, a);
    chk("t4_wresp_t3", 32'(lsu_wrespvalid), 1);
    step(0, 0, 0, 0, 0, 0, a);
    chk("t4_wresp_t4", 32'(lsu_wrespvalid), 1);
    step(0, 0, 0, 0, 0, 0, a);
    chk("t4_wresp_t5", 32'(lsu_wrespvalid), 0);

    // Error response passes through.
    step(1, 0, 0, 0, 0, 0, a);
    step(0, 0, 0, 1, 32'h0BAD_0BAD, 2'b10, a);
    chk("t5_rvalid", 32'(lsu_rvalid), 1);
    chk("t5_resp", 32'(lsu_resp), 32'h2);

    // Stray readdatavalid on an empty tracker, then reset clears it.
    step(0, 0, 0, 1, 32'h5555_5555, 0, a);
    chk("t6_perr_set", 32'(proto_err), 1);
    step(0, 0, 0, 0, 0, 0, a);
    chk("t6_perr_held", 32'(proto_err), 1);
    do_reset();
    chk("t6_rst_perr", 32'(proto_err), 0);
    chk("t6_rst_rdata", lsu_rdata, 0);
    chk("t6_rst_resp", 32'(lsu_resp), 0);
    chk("t6_rst_rvalid", 32'(lsu_rvalid), 0);
    chk("t6_rst_wresp", 32'(lsu_wrespvalid), 0);

    // Randomised traffic from a core that holds its request until accepted.
    pend_rd = 0;
    pend_wr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset();
        pend_rd = 0;
        pend_wr = 0;
      end
      if (!pend_rd && !pend_wr) begin
        case ($urandom_range(0, 3))
          1: pend_rd = 1;
          2: pend_wr = 1;
          3: pend_rd = 1;
          default: ;
        endcase
      end
      r_wt  = ($urandom_range(0, 3) == 0);
      r_rdv = 0;
      if (q.size() != 0 && !q[0] && $urandom_range(0, 1) == 1) r_rdv = 1;
      else if ($urandom_range(0, 299) == 0) r_rdv = 1;
      step(pend_rd, pend_wr, r_wt, r_rdv, $urandom, 2'($urandom), a);
      if (a) begin
        pend_rd = 0;
        pend_wr = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_avalon_bridge.md
# lsu_avalon_bridge

Bridges the core's load/store port (lsu_read/lsu_write/lsu_busy/lsu_rvalid/lsu_wrespvalid) to a pipelined Avalon-MM master with no writeresponsevalid. Sits directly downstream of the core wrapper's LSU port and upstream of the system interconnect. Tracks outstanding transactions in order. Synthesises the write-completion strobe the core needs to retire stores. Returns read data and response with one registered stage.

## Interface
- MAX_OUTSTANDING, 4: maximum accepted-but-unanswered transactions (2..16).
- ADDR_WIDTH, 32: address width.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- lsu_read  in  1  core read request.
- lsu_write  in  1  core write request.
- lsu_addr  in  ADDR_WIDTH  byte address.
- lsu_be  in  4  byte enables.
- lsu_wdata  in  32  write data.
- lsu_busy  out  1  request not accepted this cycle.
- lsu_rvalid  out  1  read data valid.
- lsu_rdata  out  32  read data.
- lsu_resp  out  2  response code (00 OKAY).
- lsu_wrespvalid  out  1  write completed.
- avm_address  out  ADDR_WIDTH; avm_read, avm_write  out  1; avm_byteenable  out  4; avm_writedata  out  32.
- avm_waitrequest, avm_readdatavalid  in  1; avm_readdata  in  32; avm_response  in  2.
- proto_err  out  1  sticky: readdatavalid with no read at tracker head.

## Operation
- Core holds its request until it is not busy. The command path is combinational pass-through: avm_address=lsu_addr, avm_byteenable=lsu_be, avm_writedata=lsu_wdata.
- Stall conditions:
  - full = (count==MAX_OUTSTANDING).
  - rd_block = tracker holds any write entry.
- Master-side requests:
  - avm_read = lsu_read & ~full & ~rd_block.
  - avm_write = lsu_write & ~full.
- lsu_busy = ~((avm_read|avm_write) & ~avm_waitrequest), asserted only while lsu_read|lsu_write; otherwise 0.
- Accept = (avm_read|avm_write) & ~avm_waitrequest. On accept, push the kind (READ/WRITE) into the in-order tracker FIFO.
- Pop rules, at most one pop per cycle:
  - Head READ: pop on avm_readdatavalid. Register lsu_rdata=avm_readdata, lsu_resp=avm_response, lsu_rvalid=1.
  - Head WRITE: pop unconditionally. Register lsu_wrespvalid=1, lsu_resp=00.
- rd_block guarantees readdatavalid never coincides with a WRITE head.
- avm_readdatavalid while empty or head is WRITE: data dropped, proto_err set until rst.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is $clog2(MAX_OUTSTANDING+1).

## Timing
- Reset values: lsu_rvalid=0, lsu_wrespvalid=0, lsu_rdata=0, lsu_resp=00, proto_err=0, tracker empty. Combinational outputs follow inputs.
- Read: readdatavalid in cycle N gives lsu_rvalid in cycle N+1, exactly one cycle wide per beat.
- Write: accepted in cycle T; head in T+1 if the tracker is empty; lsu_wrespvalid in T+2. Queued writes drain one per cycle once they reach the head.
- Back-to-back accepts allowed every cycle until full. When a pop occurs in the same cycle as a push at full, the push is not accepted (full is evaluated on the current count).
- rst mid-operation: the tracker is cleared and the registered outputs are zeroed. Responses in flight from before the reset are reported via proto_err. The system resets the interconnect together with this block.

## Structure
- Package lsu_bridge_pkg holds:
  - typedef enum logic {TXN_READ=1'b0, TXN_WRITE=1'b1} txn_kind_e;
  - localparam AVM_RESP_OKAY=2'b00.
- Sub-module lsu_txn_fifo: parameterised depth, 1-bit txn_kind_e entries. Ports: push, pop, head, count, full, empty, has_write (count of WRITE entries != 0).
- Top level holds only the gating logic and the registered response stage.

## Test plan
- Single read, slave waitrequest=1 for 2 cycles, readdata=0xDEADBEEF one cycle after accept → lsu_busy high 2 cycles, lsu_rvalid=1 and lsu_rdata=0xDEADBEEF one cycle after readdatavalid, lsu_resp=00.
- Four back-to-back reads with MAX_OUTSTANDING=4 and no readdatavalid → fifth read sees lsu_busy=1 and avm_read=0 until the first data returns, then is accepted the next cycle.
- Read R1 outstanding, write W1 accepted, then read R2 requested → R2 blocked (avm_read=0). R1 data gives lsu_rvalid; lsu_wrespvalid follows the next cycle; R2 is then issued.
- Three consecutive writes with waitrequest=0 → lsu_wrespvalid high for 3 consecutive cycles starting 2 cycles after the first accept.
- Read returns avm_response=2'b10 → lsu_resp=2'b10 with lsu_rvalid.
- avm_readdatavalid with empty tracker → proto_err=1 and held. rst=1 for one cycle → proto_err=0 and all registered outputs 0.
